// File: rtl/hp35_bus_pkg.sv
// Shared defaults and receiver state type for the HP-35 serial bus receiver.
package hp35_bus_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int WORD_BITS_DEF   = 56;
  localparam int INSTR_BITS_DEF  = 10;

  typedef enum logic [1:0] {
    ST_UNALIGNED,
    ST_ALIGNED,
    ST_LOCKED
  } rx_state_e;

endpackage

// File: rtl/hp35_sync_edge.sv
// Multi-flop synchronizer for one asynchronous bus line, plus a rising-edge pulse
// taken from the synchronized level.
module hp35_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/hp35_bus_rx.sv
// HP-35 serial bus receiver: deserializes bcd/is words framed by the sync line
// and hands complete, correctly framed words to a ready/valid consumer.
//
// state        | meaning
// ST_UNALIGNED | no frame boundary seen yet; next frame end only aligns
// ST_ALIGNED   | boundary known, waiting for first well-formed frame
// ST_LOCKED    | last frame was well formed and emitted
module hp35_bus_rx
  import hp35_bus_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int WORD_BITS   = WORD_BITS_DEF,
  parameter int INSTR_BITS  = INSTR_BITS_DEF
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  enable,
  input  logic                  phi2_in,
  input  logic                  sync_in,
  input  logic                  is_in,
  input  logic                  bcd_in,
  input  logic                  out_ready,
  input  logic                  clr_err,
  output logic                  out_valid,
  output logic [WORD_BITS-1:0]  out_word,
  output logic [INSTR_BITS-1:0] out_instr,
  output logic                  locked,
  output logic                  frame_err,
  output logic                  overrun,
  output logic [15:0]           frame_cnt
);

  localparam int              CNT_W    = $clog2(WORD_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);
  localparam logic [3:0]      RUN_GOOD = 4'(INSTR_BITS);

  logic       phi2_rise, sync_s, is_s, bcd_s;
  logic       unused_phi2_s;
  logic [2:0] unused_rise;

  hp35_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_phi2 (
    .clk_i(wb_clk_i), .rst_i(wb_rst_i), .d_i(phi2_in), .q_o(unused_phi2_s), .rise_o(phi2_rise));
  hp35_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sync (
    .clk_i(wb_clk_i), .rst_i(wb_rst_i), .d_i(sync_in), .q_o(sync_s), .rise_o(unused_rise[0]));
  hp35_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_is (
    .clk_i(wb_clk_i), .rst_i(wb_rst_i), .d_i(is_in), .q_o(is_s), .rise_o(unused_rise[1]));
  hp35_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_bcd (
    .clk_i(wb_clk_i), .rst_i(wb_rst_i), .d_i(bcd_in), .q_o(bcd_s), .rise_o(unused_rise[2]));

  rx_state_e              state_q;
  logic [CNT_W-1:0]       bitcnt_q;
  logic [3:0]             run_q;
  logic [WORD_BITS-1:0]   word_sr_q, word_d;
  logic [INSTR_BITS-1:0]  instr_sr_q, instr_d;
  logic                   out_valid_q, frame_err_q, overrun_q;
  logic [WORD_BITS-1:0]   out_word_q;
  logic [INSTR_BITS-1:0]  out_instr_q;
  logic [15:0]            frame_cnt_q;

  logic strobe, frame_end, good, in_frame, emit, frame_fault;

  // A nonzero sync run means the previous strobe saw sync high.
  assign strobe      = enable & phi2_rise;
  assign frame_end   = strobe & ~sync_s & (run_q != '0);
  assign good        = frame_end & (bitcnt_q == LAST_BIT) & (run_q == RUN_GOOD);
  assign in_frame    = (state_q != ST_UNALIGNED);
  assign emit        = in_frame & good;
  assign frame_fault = strobe & in_frame & (frame_end ? ~good : (bitcnt_q == LAST_BIT));
  assign word_d      = {bcd_s, word_sr_q[WORD_BITS-1:1]};
  assign instr_d     = {is_s, instr_sr_q[INSTR_BITS-1:1]};

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_UNALIGNED;
      bitcnt_q   <= '0;
      run_q      <= '0;
      word_sr_q  <= '0;
      instr_sr_q <= '0;
    end else if (!enable) begin
      state_q  <= ST_UNALIGNED;
      bitcnt_q <= '0;
      run_q    <= '0;
    end else if (strobe) begin
      word_sr_q <= word_d;
      if (sync_s) begin
        instr_sr_q <= instr_d;
        if (run_q != 4'hF) run_q <= run_q + 4'd1;
      end else begin
        run_q <= '0;
      end
      case (state_q)
        ST_UNALIGNED: begin
          if (frame_end) state_q <= ST_ALIGNED;
          bitcnt_q <= '0;
        end
        default: begin
          if (frame_end) begin
            bitcnt_q <= '0;
            state_q  <= good ? ST_LOCKED : ST_UNALIGNED;
          end else if (bitcnt_q == LAST_BIT) begin
            bitcnt_q <= '0;
            state_q  <= ST_UNALIGNED;
          end else begin
            bitcnt_q <= bitcnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_instr_q <= '0;
      frame_cnt_q <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (emit && (!out_valid_q || out_ready)) begin
        out_valid_q <= 1'b1;
        out_word_q  <= word_d;
        out_instr_q <= instr_sr_q;
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      // A fresh error in the same cycle as clr_err keeps the flag set.
      if (emit && out_valid_q && !out_ready) overrun_q <= 1'b1;
      else if (clr_err)                      overrun_q <= 1'b0;
      if (frame_fault)  frame_err_q <= 1'b1;
      else if (clr_err) frame_err_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign out_instr = out_instr_q;
  assign frame_cnt = frame_cnt_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign locked    = (state_q == ST_LOCKED);

endmodule
